// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output path: framer state encoding,
// burst/point widths, the complex sample type and a frame-total helper.
package fft_pkg;

    localparam int FFT_MAX_POINT = 1024;
    localparam int FFT_BURST_W   = 10;
    localparam int FFT_POINT_W   = $clog2(FFT_MAX_POINT) + 1;
    localparam int FFT_TOTAL_W   = FFT_BURST_W + FFT_POINT_W;
    localparam int FFT_DATA_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } fsm_state_t;

    typedef struct packed {
        logic [FFT_DATA_W-1:0] imag;
        logic [FFT_DATA_W-1:0] re;
    } cplx_t;

    // Number of samples in a whole burst: (burst + 1) * point.
    function automatic logic [FFT_TOTAL_W-1:0] frame_total(
        input logic [FFT_BURST_W-1:0] burst,
        input logic [FFT_POINT_W-1:0] point
    );
        return (FFT_TOTAL_W'(burst) + FFT_TOTAL_W'(1)) * FFT_TOTAL_W'(point);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags and synchronous flush.
// A write while full is accepted when a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok   = rd_en & ~empty;
    assign wr_ok   = wr_en & (~full | rd_ok);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fft_out_framer.sv
// AXI4-Stream framer for the FFT result stream: FIFO buffering, tlast every
// r_point beats, burst completion. FFT_OUT_FRAMER_OVF_EN adds sticky o_overflow.
module fft_out_framer
    import fft_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_start,
    input  logic [FFT_BURST_W-1:0] i_burst,
    input  logic [FFT_POINT_W-1:0] i_point,
    input  logic                   i_valid,
    input  logic [2*DATA_W-1:0]    i_data,
    output logic [2*DATA_W-1:0]    m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   o_busy,
    output logic                   o_done,
`ifdef FFT_OUT_FRAMER_OVF_EN
    output logic                   o_overflow,
`endif
    output logic [FFT_BURST_W-1:0] o_frame_cnt
);

    fsm_state_t             cs;
    logic                   start_d;
    logic [FFT_POINT_W-1:0] r_point;
    logic [FFT_BURST_W-1:0] r_burst;
    logic [FFT_TOTAL_W-1:0] r_total;
    logic [FFT_TOTAL_W-1:0] in_cnt;
    logic [FFT_POINT_W-1:0] point_cnt;
    logic [FFT_BURST_W-1:0] frame_cnt;

    logic                   start_pulse;
    logic                   run;
    logic                   in_room;
    logic                   wr;
    logic                   rd;
    logic                   last_pt;
    logic                   flush;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [2*DATA_W-1:0]    head;

    assign start_pulse   = i_start & ~start_d;
    assign run           = (cs == RUN);
    assign flush         = (cs == IDLE) & start_pulse;
    assign in_room       = (in_cnt < r_total);
    assign m_axis_tvalid = run & ~fifo_empty;
    assign rd            = m_axis_tvalid & m_axis_tready;
    assign wr            = run & i_valid & in_room & (~fifo_full | rd);
    assign last_pt       = (point_cnt == r_point - FFT_POINT_W'(1));
    assign m_axis_tlast  = m_axis_tvalid & last_pt;
    // Gate the head so tdata reads 0 whenever nothing is offered (incl. reset).
    assign m_axis_tdata  = m_axis_tvalid ? head : '0;
    assign o_frame_cnt   = frame_cnt;

    sync_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .wr_en   (wr),
        .wr_data (i_data),
        .rd_en   (rd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) start_d <= 1'b0;
        else          start_d <= i_start;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs        <= IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            r_point   <= '0;
            r_burst   <= '0;
            r_total   <= '0;
            in_cnt    <= '0;
            point_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            case (cs)
                IDLE: begin
                    o_done <= 1'b0;
                    if (start_pulse) begin
                        cs        <= RUN;
                        o_busy    <= 1'b1;
                        r_point   <= i_point;
                        r_burst   <= i_burst;
                        r_total   <= frame_total(i_burst, i_point);
                        in_cnt    <= '0;
                        point_cnt <= '0;
                        frame_cnt <= '0;
                    end
                end
                RUN: begin
                    if (wr) in_cnt <= in_cnt + FFT_TOTAL_W'(1);
                    if (rd) begin
                        if (last_pt) begin
                            point_cnt <= '0;
                            // The final frame ends the burst without bumping frame_cnt.
                            if (frame_cnt == r_burst) begin
                                cs     <= DONE;
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                            end else begin
                                frame_cnt <= frame_cnt + FFT_BURST_W'(1);
                            end
                        end else begin
                            point_cnt <= point_cnt + FFT_POINT_W'(1);
                        end
                    end
                end
                DONE: begin
                    cs     <= IDLE;
                    o_done <= 1'b0;
                end
                default: begin
                    cs     <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef FFT_OUT_FRAMER_OVF_EN
    logic drop;
    assign drop = run & i_valid & in_room & fifo_full & ~rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   o_overflow <= 1'b0;
        else if (flush) o_overflow <= 1'b0;
        else if (drop)  o_overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fft_out_framer.sv
// Scoreboard bench for fft_out_framer: expected beats are queued as samples
// are driven and compared as the AXI-Stream master hands them off.
`timescale 1ns/1ps
module tb_fft_out_framer;
    import fft_pkg::*;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   i_start = 1'b0;
    logic [FFT_BURST_W-1:0] i_burst = '0;
    logic [FFT_POINT_W-1:0] i_point = 11'd8;
    logic                   i_valid = 1'b0;
    logic [2*DATA_W-1:0]    i_data = '0;
    logic [2*DATA_W-1:0]    m_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready = 1'b0;
    logic                   m_axis_tlast;
    logic                   o_busy;
    logic                   o_done;
    logic [FFT_BURST_W-1:0] o_frame_cnt;
`ifdef FFT_OUT_FRAMER_OVF_EN
    logic                   o_overflow;
`endif

    fft_out_framer #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_burst       (i_burst),
        .i_point       (i_point),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .o_busy        (o_busy),
        .o_done        (o_done),
`ifdef FFT_OUT_FRAMER_OVF_EN
        .o_overflow    (o_overflow),
`endif
        .o_frame_cnt   (o_frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*DATA_W-1:0]    data;
        logic                   last;
        logic                   fin;
        logic [FFT_BURST_W-1:0] fidx;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   acc = 0;
    int   cur_point = 8;
    int   cur_total = 8;
    int   done_cnt = 0;
    logic rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [2*DATA_W-1:0] d);
        exp_t e;
        e.data = d;
        e.last = ((acc % cur_point) == cur_point - 1);
        e.fin  = (acc == cur_total - 1);
        e.fidx = FFT_BURST_W'(acc / cur_point);
        sb.push_back(e);
        acc++;
    endtask

    // Drive one cycle of input; the caller is left at posedge + 1.
    task automatic drive(input logic v, input logic accept);
        logic [2*DATA_W-1:0] d;
        d = $urandom;
        i_valid = v;
        i_data  = d;
        if (v && accept) push(d);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start_burst(input int point, input int burst);
        i_point   = FFT_POINT_W'(point);
        i_burst   = FFT_BURST_W'(burst);
        cur_point = point;
        cur_total = (burst + 1) * point;
        acc       = 0;
        i_start   = 1'b1;
        @(posedge clk); #1;
        i_start   = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        repeat (3) begin @(posedge clk); #1; end
        check("drained", 64'(sb.size()), 0);
    endtask

    // Ready generator for the random-backpressure test.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: scoreboard compare, done pulse, frame count, stall stability.
    initial begin
        exp_t                   e;
        logic                   exp_done = 1'b0;
        logic                   fc_chk = 1'b0;
        logic [FFT_BURST_W-1:0] fc_exp = '0;
        logic                   prev_stall = 1'b0;
        logic [2*DATA_W-1:0]    prev_data = '0;
        logic                   prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_done   = 1'b0;
                fc_chk     = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("o_done", o_done, exp_done);
                if (exp_done) check("busy_at_done", o_busy, 0);
                if (fc_chk) check("frame_cnt", o_frame_cnt, fc_exp);
                if (prev_stall && m_axis_tvalid) begin
                    check("hold_tdata", m_axis_tdata, prev_data);
                    check("hold_tlast", m_axis_tlast, prev_last);
                end
                exp_done = 1'b0;
                fc_chk   = 1'b0;
                if (o_done) done_cnt++;
                if (m_axis_tvalid && m_axis_tready) begin
                    check("beat_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("tdata", m_axis_tdata, e.data);
                        check("tlast", m_axis_tlast, e.last);
                        if (e.last && !e.fin) begin
                            fc_chk = 1'b1;
                            fc_exp = e.fidx + FFT_BURST_W'(1);
                        end
                        exp_done = e.fin;
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_frame_cnt", o_frame_cnt, 0);
`ifdef FFT_OUT_FRAMER_OVF_EN
        check("rst_overflow", o_overflow, 0);
`endif
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        m_axis_tready = 1'b1;

        // i_valid in IDLE is discarded
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_data  = $urandom;
            @(negedge clk);
            check("idle_tvalid", m_axis_tvalid, 0);
            @(posedge clk); #1;
        end
        idle(2);

        // Single 8-point frame, first-beat latency
        d0 = done_cnt;
        start_burst(8, 0);
        drive_first: begin
            logic [2*DATA_W-1:0] d;
            d = $urandom;
            i_valid = 1'b1; i_data = d; push(d);
            @(negedge clk);
            check("lat_empty", m_axis_tvalid, 0);
            check("busy_run", o_busy, 1);
            check("frame_cnt_start", o_frame_cnt, 0);
            @(posedge clk); #1;
            d = $urandom;
            i_data = d; push(d);
            @(negedge clk);
            check("lat_n1", m_axis_tvalid, 1);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b1);
        idle(1);
        wait_drain(50);
        check("t1_done_pulses", 64'(done_cnt - d0), 1);
        check("t1_frame_cnt", o_frame_cnt, 0);
        check("t1_busy", o_busy, 0);

        // Four 16-point frames
        d0 = done_cnt;
        start_burst(16, 3);
        for (int k = 0; k < 64; k++) drive(1'b1, 1'b1);
        idle(1);
        wait_drain(100);
        check("t2_done_pulses", 64'(done_cnt - d0), 1);
        check("t2_frame_cnt_hold", o_frame_cnt, 3);

        // Random backpressure, bursty input paced within FIFO capacity
        d0 = done_cnt;
        start_burst(64, 0);
        rand_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            int w;
            for (int k = 0; k < 8; k++) drive(1'b1, 1'b1);
            i_valid = 1'b0;
            w = 0;
            while (sb.size() > 8 && w < 200) begin
                @(posedge clk); #1;
                w++;
            end
            check("pace_bound", sb.size() <= 8, 1);
        end
        wait_drain(500);
        rand_ready = 1'b0;
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        check("t3_done_pulses", 64'(done_cnt - d0), 1);

        // Overflow: 20 samples against a stalled sink, 4 dropped
        d0 = done_cnt;
        start_burst(32, 0);
        m_axis_tready = 1'b0;
        for (int k = 0; k < 20; k++) drive(1'b1, k < FIFO_DEPTH);
        i_valid = 1'b0;
        @(negedge clk);
        check("ovf_tvalid", m_axis_tvalid, 1);
`ifdef FFT_OUT_FRAMER_OVF_EN
        check("ovf_set", o_overflow, 1);
`endif
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        wait_drain(50);
        for (int k = 0; k < 16; k++) drive(1'b1, 1'b1);
        idle(1);
        wait_drain(50);
        check("t4_done_pulses", 64'(done_cnt - d0), 1);
`ifdef FFT_OUT_FRAMER_OVF_EN
        check("ovf_sticky", o_overflow, 1);
`endif

        // Extra i_valid past the burst total, then in IDLE
        d0 = done_cnt;
        start_burst(8, 0);
`ifdef FFT_OUT_FRAMER_OVF_EN
        @(negedge clk);
        check("ovf_cleared", o_overflow, 0);
        @(posedge clk); #1;
`endif
        for (int k = 0; k < 18; k++) drive(1'b1, k < 8);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0);
        idle(5);
        wait_drain(50);
        check("t5_done_pulses", 64'(done_cnt - d0), 1);
        check("t5_tvalid_idle", m_axis_tvalid, 0);

        // Asynchronous reset mid-frame, then a clean frame
        start_burst(8, 0);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b1);
        m_axis_tready = 1'b0;
        for (int k = 0; k < 2; k++) drive(1'b1, 1'b1);
        i_valid = 1'b0;
        check("pre_rst_tvalid", m_axis_tvalid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_tvalid", m_axis_tvalid, 0);
        check("arst_tlast", m_axis_tlast, 0);
        check("arst_tdata", m_axis_tdata, 0);
        check("arst_busy", o_busy, 0);
        check("arst_done", o_done, 0);
        check("arst_frame_cnt", o_frame_cnt, 0);
        sb.delete();
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        check("post_rst_tvalid", m_axis_tvalid, 0);
        d0 = done_cnt;
        start_burst(8, 0);
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b1);
        idle(1);
        wait_drain(50);
        check("t6_done_pulses", 64'(done_cnt - d0), 1);
        check("t6_frame_cnt", o_frame_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
